alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  Produces the 4-bit ALU control code and the operand pair for the 64-bit ALU.
//  Sits between the decode stage and the ALU.
//  Accepts {ALUOp, funct3, funct7[5], a, b} on a valid/ready interface, decodes the fields to a control code,
//  and registers the result into a 2-entry skid buffer with a valid/ready output.
//  Provides full throughput and breaks the ready path combinationally.
// PARAMETERS
//  DATA_W   64  operand width; must match the ALU width
//  CNT_W    8   illegal-op counter width; used only with ALU_ILLEGAL_CNT_EN
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       upstream beat valid
//  in_ready     out  1       upstream may transfer when in_valid & in_ready
//  alu_op       in   2       00 mem(add), 01 branch, 10 R-type, 11 reserved
//  funct3       in   3       instruction funct3
//  funct7_5     in   1       instruction bit 30
//  a_in         in   DATA_W  operand A
//  b_in         in   DATA_W  operand B
//  out_valid    out  1       ALU beat valid
//  out_ready    in   1       ALU side accepts when out_valid & out_ready
//  alu_control  out  4       control code to the ALU
//  a_out        out  DATA_W  registered operand A
//  b_out        out  DATA_W  registered operand B
//  illegal      out  1       current output beat was an illegal encoding
//  illegal_cnt  out  CNT_W   saturating illegal-beat count (ALU_ILLEGAL_CNT_EN only)
// BEHAVIOUR
//  Decode:
//   - alu_op 00 -> 0000 ADD.
//   - alu_op 01 with funct3 000 -> 1010 BEQ.
//   - alu_op 10 with funct3 000 -> 0000 ADD if funct7_5=0, 0001 SUB if funct7_5=1.
//   - alu_op 10 with funct3 111 -> 0100 AND.
//   - alu_op 10 with funct3 110 -> 0101 OR.
//   - Any other combination -> 1111 with illegal=1. The ALU returns 0 for 1111.
//   - Illegal beats still flow through the buffer, in order.
//  Reset (asynchronous, rst=1):
//   - State goes to EMPTY; all outputs are 0 except in_ready=1.
//   - alu_control=0000, a_out=b_out=0.
//   - Any buffered beat is discarded.
//  State machine, based on transfers in = in_valid&in_ready and out = out_valid&out_ready:
//   - EMPTY: in -> ONE.
//   - ONE: in&!out -> FULL. !in&out -> EMPTY. in&out -> ONE (main reloads).
//   - FULL: out -> ONE (skid moves to main). in_ready=0, so no in in FULL.
//  Outputs per state:
//   - in_ready = (state != FULL), driven from a registered state only.
//   - out_valid = (state != EMPTY).
//  Latency: 1 cycle from an accepted input to out_valid. Sustains 1 beat/cycle while out_ready=1.
//  Ordering: strict FIFO. out_* is held stable while out_valid & !out_ready.
//  Width: operands pass through unmodified; there is no arithmetic in this block.
// CONFIGURATION
//  ALU_ILLEGAL_CNT_EN defined:
//   - illegal_cnt increments on each output transfer with illegal=1.
//   - It saturates at 2^CNT_W-1 and clears only on rst.
//  ALU_ILLEGAL_CNT_EN undefined:
//   - The illegal_cnt port and its counter are absent.
//   - All other behaviour is identical.
// STRUCTURE
//  Package alu_pkg:
//   - ALU control localparams CTL_ADD 0000, CTL_SUB 0001, CTL_AND 0100, CTL_OR 0101, CTL_BEQ 1010, CTL_ILL 1111.
//   - ALUOp encodings.
//   - Skid state encoding {EMPTY, ONE, FULL}.
//  Sub-module alu_ctrl_decode:
//   - Purely combinational: {alu_op, funct3, funct7_5} -> {control, illegal}.
//  Top: skid buffer (main and skid registers), FSM, optional counter.
// TESTING
//  T1: rst mid-stream with state FULL -> next cycle out_valid=0, in_ready=1, alu_control=0000, buffer empty.
//  T2: alu_op=10, funct3=000, funct7_5=1, a=5, b=3, out_ready=1 -> next cycle alu_control=0001, a_out=5, b_out=3, illegal=0.
//  T3: Stream of ADD, AND(111), OR(110), BEQ(01/000) with out_ready=1 ->
//      codes 0000, 0100, 0101, 1010 on consecutive cycles, no bubbles.
//  T4: out_ready=0 while 3 beats are offered ->
//      2 beats accepted, then in_ready=0 and out_* stable;
//      set out_ready=1 -> beats drain in order, after which in_ready=1.
//  T5: alu_op=11, and alu_op=01 with funct3=001 -> alu_control=1111, illegal=1;
//      with ALU_ILLEGAL_CNT_EN, illegal_cnt=2.
//  T6: CNT_W=2 and 5 illegal beats -> illegal_cnt saturates at 3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control issue stage: control codes, ALUOp values, skid states.
package alu_pkg;

    localparam logic [3:0] CTL_ADD = 4'b0000;
    localparam logic [3:0] CTL_SUB = 4'b0001;
    localparam logic [3:0] CTL_AND = 4'b0100;
    localparam logic [3:0] CTL_OR  = 4'b0101;
    localparam logic [3:0] CTL_BEQ = 4'b1010;
    localparam logic [3:0] CTL_ILL = 4'b1111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    typedef enum logic [1:0] {
        AluOpMem    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpRtype  = 2'b10,
        AluOpRsvd   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } skid_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {ALUOp, funct3, funct7[5]} into a 4-bit ALU control code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    output logic [3:0] ctl_o,
    output logic       illegal_o
);

    always_comb begin
        ctl_o     = CTL_ILL;
        illegal_o = 1'b1;
        unique case (alu_op_e'(alu_op_i))
            AluOpMem: begin
                ctl_o     = CTL_ADD;
                illegal_o = 1'b0;
            end
            AluOpBranch: begin
                if (funct3_i == F3_BEQ) begin
                    ctl_o     = CTL_BEQ;
                    illegal_o = 1'b0;
                end
            end
            AluOpRtype: begin
                unique case (funct3_i)
                    F3_ADD_SUB: begin
                        ctl_o     = funct7_5_i ? CTL_SUB : CTL_ADD;
                        illegal_o = 1'b0;
                    end
                    F3_AND: begin
                        ctl_o     = CTL_AND;
                        illegal_o = 1'b0;
                    end
                    F3_OR: begin
                        ctl_o     = CTL_OR;
                        illegal_o = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: decode + 2-entry skid buffer toward the ALU.
// Optional saturating illegal-beat counter enabled by defining ALU_ILLEGAL_CNT_EN.
module alu_ctrl_issue
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
`ifdef ALU_ILLEGAL_CNT_EN
    output logic [CNT_W-1:0]  illegal_cnt,
`endif
    output logic              illegal
);

    skid_state_e       state_q;
    logic [3:0]        main_ctl_q, skid_ctl_q;
    logic              main_ill_q, skid_ill_q;
    logic [DATA_W-1:0] main_a_q, main_b_q, skid_a_q, skid_b_q;

    logic [3:0] dec_ctl;
    logic       dec_ill;
    logic       in_xfer, out_xfer;

    alu_ctrl_decode u_decode (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7_5_i (funct7_5),
        .ctl_o      (dec_ctl),
        .illegal_o  (dec_ill)
    );

    // Handshakes depend only on registered state, so in_ready never sees out_ready.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    assign alu_control = main_ctl_q;
    assign a_out       = main_a_q;
    assign b_out       = main_b_q;
    assign illegal     = out_valid & main_ill_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            main_ctl_q <= CTL_ADD;
            main_ill_q <= 1'b0;
            main_a_q   <= '0;
            main_b_q   <= '0;
            skid_ctl_q <= CTL_ADD;
            skid_ill_q <= 1'b0;
            skid_a_q   <= '0;
            skid_b_q   <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_ctl_q <= dec_ctl;
                        main_ill_q <= dec_ill;
                        main_a_q   <= a_in;
                        main_b_q   <= b_in;
                        state_q    <= StOne;
                    end
                end
                StOne: begin
                    if (in_xfer && !out_xfer) begin
                        skid_ctl_q <= dec_ctl;
                        skid_ill_q <= dec_ill;
                        skid_a_q   <= a_in;
                        skid_b_q   <= b_in;
                        state_q    <= StFull;
                    end else if (in_xfer && out_xfer) begin
                        main_ctl_q <= dec_ctl;
                        main_ill_q <= dec_ill;
                        main_a_q   <= a_in;
                        main_b_q   <= b_in;
                    end else if (out_xfer) begin
                        state_q <= StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_ctl_q <= skid_ctl_q;
                        main_ill_q <= skid_ill_q;
                        main_a_q   <= skid_a_q;
                        main_b_q   <= skid_b_q;
                        state_q    <= StOne;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

`ifdef ALU_ILLEGAL_CNT_EN
    logic [CNT_W-1:0] illegal_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt_q <= '0;
        end else if (out_xfer && main_ill_q && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_q <= illegal_cnt_q + CNT_W'(1);
        end
    end

    assign illegal_cnt = illegal_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed self-checking bench for alu_ctrl_issue (counter checks active with ALU_ILLEGAL_CNT_EN).
module tb_alu_ctrl_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_5 = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  alu_control;
    logic [63:0] a_out;
    logic [63:0] b_out;
    logic        illegal;
`ifdef ALU_ILLEGAL_CNT_EN
    logic [1:0]  illegal_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_issue #(
        .DATA_W (64),
        .CNT_W  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .a_in        (a_in),
        .b_in        (b_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .a_out       (a_out),
        .b_out       (b_out),
`ifdef ALU_ILLEGAL_CNT_EN
        .illegal_cnt (illegal_cnt),
`endif
        .illegal     (illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] f3,
                         input logic f7, input logic [63:0] a, input logic [63:0] b);
        in_valid = v;
        alu_op   = op;
        funct3   = f3;
        funct7_5 = f7;
        a_in     = a;
        b_in     = b;
    endtask

    task automatic test_reset();
        step();
        checks++;
        if ({out_valid, in_ready, alu_control, illegal} !== {1'b0, 1'b1, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_hs: got ov=%b ir=%b ctl=%b ill=%b want 0 1 0000 0",
                     out_valid, in_ready, alu_control, illegal);
        end
        checks++;
        if ({a_out, b_out} !== 128'd0) begin
            errors++;
            $display("FAIL reset_ops: got a=%h b=%h want 0 0", a_out, b_out);
        end
        rst = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_sub();
        out_ready = 1'b1;
        drive(1'b1, 2'b10, 3'b000, 1'b1, 64'd5, 64'd3);
        step();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        checks++;
        if ({out_valid, alu_control, illegal} !== {1'b1, 4'b0001, 1'b0}) begin
            errors++;
            $display("FAIL sub_ctl: got ov=%b ctl=%b ill=%b want 1 0001 0",
                     out_valid, alu_control, illegal);
        end
        checks++;
        if (a_out !== 64'd5 || b_out !== 64'd3) begin
            errors++;
            $display("FAIL sub_ops: got a=%0d b=%0d want 5 3", a_out, b_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        logic [2:0] f3s [4] = '{3'b000, 3'b111, 3'b110, 3'b000};
        logic [3:0] exp [4] = '{4'b0000, 4'b0100, 4'b0101, 4'b1010};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ops[i], f3s[i], 1'b0, 64'(i + 20), 64'(i + 40));
            step();
            checks++;
            if ({out_valid, in_ready, alu_control, illegal} !== {1'b1, 1'b1, exp[i], 1'b0}
                || a_out !== 64'(i + 20) || b_out !== 64'(i + 40)) begin
                errors++;
                $display("FAIL b2b_%0d: got ov=%b ir=%b ctl=%b ill=%b a=%0d b=%0d want 1 1 %b 0 %0d %0d",
                         i, out_valid, in_ready, alu_control, illegal, a_out, b_out,
                         exp[i], i + 20, i + 40);
            end
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 2'b11, 3'b000, 1'b0, 64'd7, 64'd8);
        step();
        checks++;
        if ({out_valid, alu_control, illegal} !== {1'b1, 4'b1111, 1'b1} || a_out !== 64'd7) begin
            errors++;
            $display("FAIL ill_rsvd: got ov=%b ctl=%b ill=%b a=%0d want 1 1111 1 7",
                     out_valid, alu_control, illegal, a_out);
        end
        drive(1'b1, 2'b01, 3'b001, 1'b0, 64'd9, 64'd10);
        step();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        checks++;
        if ({out_valid, alu_control, illegal} !== {1'b1, 4'b1111, 1'b1} || b_out !== 64'd10) begin
            errors++;
            $display("FAIL ill_bne: got ov=%b ctl=%b ill=%b b=%0d want 1 1111 1 10",
                     out_valid, alu_control, illegal, b_out);
        end
        step();
`ifdef ALU_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 2'd2) begin
            errors++;
            $display("FAIL ill_cnt: got %0d want 2", illegal_cnt);
        end
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ill_drain: got ov=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b11, 3'(i), 1'b0, 64'd0, 64'd0);
            step();
        end
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        step();
`ifdef ALU_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 2'd3) begin
            errors++;
            $display("FAIL sat_cnt: got %0d want 3", illegal_cnt);
        end
`endif
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL sat_idle_ill: got %b want 0", illegal);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 3'b000, 1'b0, 64'd10, 64'd110);
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b11 || a_out !== 64'd10) begin
            errors++;
            $display("FAIL bp_first: got ov=%b ir=%b a=%0d want 1 1 10", out_valid, in_ready, a_out);
        end
        drive(1'b1, 2'b10, 3'b111, 1'b0, 64'd11, 64'd111);
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b10 || a_out !== 64'd10) begin
            errors++;
            $display("FAIL bp_full: got ov=%b ir=%b a=%0d want 1 0 10", out_valid, in_ready, a_out);
        end
        drive(1'b1, 2'b10, 3'b110, 1'b0, 64'd12, 64'd112);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({in_ready, alu_control} !== {1'b0, 4'b0000} || a_out !== 64'd10
                || b_out !== 64'd110) begin
                errors++;
                $display("FAIL bp_hold_%0d: got ir=%b ctl=%b a=%0d b=%0d want 0 0000 10 110",
                         i, in_ready, alu_control, a_out, b_out);
            end
        end
        out_ready = 1'b1;
        step();
        checks++;
        if ({out_valid, in_ready, alu_control} !== {1'b1, 1'b1, 4'b0100} || a_out !== 64'd11) begin
            errors++;
            $display("FAIL bp_drain1: got ov=%b ir=%b ctl=%b a=%0d want 1 1 0100 11",
                     out_valid, in_ready, alu_control, a_out);
        end
        step();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        checks++;
        if ({out_valid, alu_control} !== {1'b1, 4'b0101} || a_out !== 64'd12) begin
            errors++;
            $display("FAIL bp_drain2: got ov=%b ctl=%b a=%0d want 1 0101 12",
                     out_valid, alu_control, a_out);
        end
        step();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL bp_empty: got ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 3'b111, 1'b0, 64'd31, 64'd32);
        step();
        drive(1'b1, 2'b11, 3'b000, 1'b0, 64'd33, 64'd34);
        step();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 64'd0, 64'd0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rf_full: got ir=%b want 0", in_ready);
        end
        #2 rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, alu_control, illegal} !== {1'b0, 1'b1, 4'b0000, 1'b0}
            || a_out !== 64'd0 || b_out !== 64'd0) begin
            errors++;
            $display("FAIL rf_reset: got ov=%b ir=%b ctl=%b ill=%b a=%0d b=%0d want 0 1 0000 0 0 0",
                     out_valid, in_ready, alu_control, illegal, a_out, b_out);
        end
`ifdef ALU_ILLEGAL_CNT_EN
        checks++;
        if (illegal_cnt !== 2'd0) begin
            errors++;
            $display("FAIL rf_cnt: got %0d want 0", illegal_cnt);
        end
`endif
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rf_discard: got ov=%b want 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_back_to_back();
        test_illegal();
        test_saturate();
        test_backpressure();
        test_reset_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
